// File: rtl/fifo2axis_video.sv
// fifo2axis_video: unpack FWFT FIFO words into an AXI4-Stream video master with SOF/EOL framing
module fifo2axis_video #(
  parameter int FAW             = 8,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = 128,
  parameter int H_ACTIVE        = 1920,
  parameter int V_ACTIVE        = 1080
) (
  input  logic                         S_AXIS_ACLK,
  input  logic                         S_AXIS_ARESETN,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                         M_AXIS_TLAST,
  output logic                         M_AXIS_TUSER,
  output logic                         frd_rdy,
  input  logic                         frd_vld,
  input  logic [FIFO_DATA_WIDTH-1:0]   frd_dat,
  input  logic                         frd_empty,
  input  logic [FAW:0]                 frd_cnt,
  input  logic                         enable,
  input  logic                         frame_start,
  output logic                         frame_done,
  output logic                         underflow
);
  localparam int RATIO = FIFO_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int SW    = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int XW    = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
  localparam int YW    = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
  localparam int TOTAL = H_ACTIVE * V_ACTIVE / RATIO;
  localparam int PW    = $clog2(TOTAL + 1);
  localparam logic [SW-1:0] LAST_SUB = SW'(RATIO - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [PW-1:0] POPS     = PW'(TOTAL);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                     state;
  logic [FIFO_DATA_WIDTH-1:0] word_reg;
  logic                       word_loaded;
  logic [SW-1:0]              sub_idx;
  logic [XW-1:0]              x_cnt;
  logic [YW-1:0]              y_cnt;
  logic [PW-1:0]              pops_left;
  logic                       started;
  logic                       last_sub, beat, pop, last_beat;
  logic                       unused_status;

  assign unused_status = frd_empty ^ (^frd_cnt);

  assign last_sub  = sub_idx == LAST_SUB;
  assign beat      = word_loaded & M_AXIS_TREADY;
  assign frd_rdy   = state == ACTIVE && pops_left != '0 && (!word_loaded || (M_AXIS_TREADY && last_sub));
  assign pop       = frd_rdy & frd_vld;
  assign last_beat = beat && x_cnt == X_LAST && y_cnt == Y_LAST;

  assign M_AXIS_TVALID = word_loaded;
  assign M_AXIS_TDATA  = word_reg[sub_idx*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = word_loaded && x_cnt == X_LAST;
  assign M_AXIS_TUSER  = word_loaded && x_cnt == '0 && y_cnt == '0;
  assign frame_done    = state == DONE;
  assign underflow     = state == ACTIVE && started && !word_loaded && pops_left != '0 && !frd_vld;

  // Frame sequencing: arm one frame's worth of pops on start, finish after the last accepted beat
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state     <= IDLE;
      pops_left <= '0;
      started   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (frame_start && enable) begin
          state     <= ACTIVE;
          pops_left <= POPS;
          started   <= 1'b0;
        end
        ACTIVE: begin
          if (pop) pops_left <= pops_left - 1'b1;
          if (beat) started <= 1'b1;
          if (last_beat) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word holding register: a pop reloads it, accepted beats walk through its slices LSB first
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      word_reg    <= '0;
      word_loaded <= 1'b0;
      sub_idx     <= '0;
    end else if (pop) begin
      word_reg    <= frd_dat;
      word_loaded <= 1'b1;
      sub_idx     <= '0;
    end else if (beat) begin
      sub_idx     <= last_sub ? '0 : sub_idx + 1'b1;
      word_loaded <= !last_sub;
    end
  end

  // Raster position, advanced only by accepted beats so TLAST/TUSER stay stable through stalls
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (beat) begin
      x_cnt <= x_cnt == X_LAST ? '0 : x_cnt + 1'b1;
      y_cnt <= x_cnt != X_LAST ? y_cnt : y_cnt == Y_LAST ? '0 : y_cnt + 1'b1;
    end
  end
endmodule
